vc_read_arbiter: RTL and testbench

//  Consumer end of the two virtual-channel FIFOs (VC0 and VC1) in the transmit-side transaction layer.

---
 rtl/vc_read_arbiter_pkg.sv | 26 ++
 rtl/vc_read_arbiter_grant_select.sv | 34 +++
 rtl/vc_read_arbiter.sv | 138 +++++++++++++
 tb/tb_vc_read_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/vc_read_arbiter_pkg.sv
// Shared state encoding, destination-field helpers and sizing constants for the
// VC read arbiter and its grant selector.
package vc_arb_pkg;

  localparam int DEST_W     = 2;
  localparam int NUM_DEST   = 4;
  localparam int WORD_MAX_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    POP    = 2'd1,
    CAP    = 2'd2,
    SETTLE = 2'd3
  } arb_state_t;

  // Destination index sits in the top DEST_W bits of a word that is `width` bits wide.
  function automatic logic [DEST_W-1:0] dest_field(input logic [WORD_MAX_W-1:0] word,
                                                   input int unsigned width);
    dest_field = word[width-1 -: DEST_W];
  endfunction

  function automatic logic [NUM_DEST-1:0] dest_onehot(input logic [DEST_W-1:0] dest);
    dest_onehot = {{(NUM_DEST-1){1'b0}}, 1'b1} << dest;
  endfunction

endpackage

// File: rtl/vc_read_arbiter_grant_select.sv
// Combinational grant decision: per-VC eligibility against empties and destination
// backpressure, VC0 priority with a starvation override in favour of VC1.
module vc_grant_select
  import vc_arb_pkg::*;
#(
  parameter int STARVE_W = 4
) (
  input  logic                init,
  input  logic                empty_vc0,
  input  logic                empty_vc1,
  input  logic [DEST_W-1:0]   dest_vc0,
  input  logic [DEST_W-1:0]   dest_vc1,
  input  logic [NUM_DEST-1:0] dest_almost_full,
  input  logic [STARVE_W-1:0] starve_cnt,
  input  logic [STARVE_W-1:0] starve_limit,
  output logic                grant_vc0,
  output logic                grant_vc1
);

  logic elig_vc0_s;
  logic elig_vc1_s;
  logic starved_s;

  // Eligibility, starvation override and mutually exclusive grant.
  always_comb begin
    elig_vc0_s = init & ~empty_vc0 & ~dest_almost_full[dest_vc0];
    elig_vc1_s = init & ~empty_vc1 & ~dest_almost_full[dest_vc1];
    // A zero limit means strict VC0 priority; the override never fires.
    starved_s  = elig_vc1_s & (starve_limit != {STARVE_W{1'b0}}) & (starve_cnt >= starve_limit);
    grant_vc0  = elig_vc0_s & ~starved_s;
    grant_vc1  = elig_vc1_s & ~grant_vc0;
  end

endmodule

// File: rtl/vc_read_arbiter.sv
// Consumer end of the VC0/VC1 FIFO pair: pops one word at a time through a fixed
// IDLE/POP/CAP/SETTLE sequence and pushes it to the destination FIFO named by its top bits.
module vc_read_arbiter
  import vc_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 6,
  parameter int STARVE_W   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic                  empty_vc0,
  input  logic                  empty_vc1,
  input  logic [DATA_WIDTH-1:0] peek_vc0,
  input  logic [DATA_WIDTH-1:0] peek_vc1,
  input  logic [DATA_WIDTH-1:0] data_vc0,
  input  logic [DATA_WIDTH-1:0] data_vc1,
  input  logic [NUM_DEST-1:0]   dest_almost_full,
  input  logic [STARVE_W-1:0]   starve_limit,
  output logic                  rd_vc0,
  output logic                  rd_vc1,
  output logic [NUM_DEST-1:0]   push,
  output logic [DATA_WIDTH-1:0] push_data,
  output logic                  idle
);

  localparam logic [STARVE_W-1:0] STARVE_MAX  = {STARVE_W{1'b1}};
  localparam logic [STARVE_W-1:0] STARVE_ZERO = {STARVE_W{1'b0}};
  localparam logic [STARVE_W-1:0] STARVE_ONE  = {{(STARVE_W-1){1'b0}}, 1'b1};

  arb_state_t            state_r;
  logic                  src_r;
  logic [STARVE_W-1:0]   starve_cnt_r;

  logic                  grant_vc0_s;
  logic                  grant_vc1_s;
  logic [DEST_W-1:0]     peek_dest_vc0_s;
  logic [DEST_W-1:0]     peek_dest_vc1_s;
  logic [DATA_WIDTH-1:0] cap_word_s;
  logic [DEST_W-1:0]     cap_dest_s;
  logic [STARVE_W-1:0]   starve_after_vc0_s;

  assign peek_dest_vc0_s = dest_field(WORD_MAX_W'(peek_vc0), DATA_WIDTH);
  assign peek_dest_vc1_s = dest_field(WORD_MAX_W'(peek_vc1), DATA_WIDTH);
  assign cap_dest_s      = dest_field(WORD_MAX_W'(cap_word_s), DATA_WIDTH);

  vc_grant_select #(
    .STARVE_W(STARVE_W)
  ) u_grant_select (
    .init             (init),
    .empty_vc0        (empty_vc0),
    .empty_vc1        (empty_vc1),
    .dest_vc0         (peek_dest_vc0_s),
    .dest_vc1         (peek_dest_vc1_s),
    .dest_almost_full (dest_almost_full),
    .starve_cnt       (starve_cnt_r),
    .starve_limit     (starve_limit),
    .grant_vc0        (grant_vc0_s),
    .grant_vc1        (grant_vc1_s)
  );

  // Captured word follows the granted source; VC0 grants only count while VC1 is waiting.
  always_comb begin
    cap_word_s         = data_vc0;
    starve_after_vc0_s = STARVE_ZERO;
    if (src_r) begin
      cap_word_s = data_vc1;
    end else begin
      cap_word_s = data_vc0;
    end
    if (empty_vc1) begin
      starve_after_vc0_s = STARVE_ZERO;
    end else if (starve_cnt_r == STARVE_MAX) begin
      starve_after_vc0_s = STARVE_MAX;
    end else begin
      starve_after_vc0_s = starve_cnt_r + STARVE_ONE;
    end
  end

  // Pop/capture/push sequencer with registered strobes and starvation bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      src_r        <= 1'b0;
      starve_cnt_r <= STARVE_ZERO;
      rd_vc0       <= 1'b0;
      rd_vc1       <= 1'b0;
      push         <= {NUM_DEST{1'b0}};
      push_data    <= {DATA_WIDTH{1'b0}};
      idle         <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_vc0_s) begin
            state_r      <= POP;
            src_r        <= 1'b0;
            rd_vc0       <= 1'b1;
            idle         <= 1'b0;
            starve_cnt_r <= starve_after_vc0_s;
          end else if (grant_vc1_s) begin
            state_r      <= POP;
            src_r        <= 1'b1;
            rd_vc1       <= 1'b1;
            idle         <= 1'b0;
            starve_cnt_r <= STARVE_ZERO;
          end else begin
            state_r <= IDLE;
            idle    <= 1'b1;
          end
        end
        POP: begin
          rd_vc0  <= 1'b0;
          rd_vc1  <= 1'b0;
          state_r <= CAP;
        end
        CAP: begin
          // Routing follows the popped data, even if it disagrees with the earlier peek.
          push      <= dest_onehot(cap_dest_s);
          push_data <= cap_word_s;
          state_r   <= SETTLE;
        end
        SETTLE: begin
          push    <= {NUM_DEST{1'b0}};
          idle    <= 1'b1;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          rd_vc0  <= 1'b0;
          rd_vc1  <= 1'b0;
          push    <= {NUM_DEST{1'b0}};
          idle    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vc_read_arbiter.sv
// Bench for vc_read_arbiter: queue-based VC FIFO models, a transaction-level reference
// model checked every cycle, a grant-decision vector table and directed corner sequences.
module tb_vc_read_arbiter;

  localparam int DW = 6;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          reset, init, empty_vc0, empty_vc1;
  logic [DW-1:0] peek_vc0, peek_vc1, data_vc0, data_vc1, push_data;
  logic [3:0]    dest_almost_full, push;
  logic [SW-1:0] starve_limit;
  logic          rd_vc0, rd_vc1, idle;

  always #5 clk = ~clk;

  vc_read_arbiter #(.DATA_WIDTH(DW), .STARVE_W(SW)) dut (
    .clk(clk), .reset(reset), .init(init),
    .empty_vc0(empty_vc0), .empty_vc1(empty_vc1),
    .peek_vc0(peek_vc0), .peek_vc1(peek_vc1),
    .data_vc0(data_vc0), .data_vc1(data_vc1),
    .dest_almost_full(dest_almost_full), .starve_limit(starve_limit),
    .rd_vc0(rd_vc0), .rd_vc1(rd_vc1), .push(push), .push_data(push_data), .idle(idle)
  );

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  int glog[$];
  int gcyc[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int g = -100;
  int m_starve = 0;
  bit m_src = 1'b0;
  logic [DW-1:0] m_word = '0;
  logic [DW-1:0] m_pdata = '0;

  typedef struct {
    bit         has0;
    bit         has1;
    logic [1:0] d0;
    logic [1:0] d1;
    logic [3:0] daf;
    bit         en;
    logic [1:0] exp_rd;
  } vec_t;
  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic update_view();
    empty_vc0 = (q0.size() == 0);
    empty_vc1 = (q1.size() == 0);
    peek_vc0  = (q0.size() != 0) ? q0[0] : '0;
    peek_vc1  = (q1.size() != 0) ? q1[0] : '0;
  endtask

  // Reference: a grant opens a 4-cycle window; strobe 1 cycle after, push 3 cycles after.
  task automatic model_step();
    bit el0, el1, g0, g1, exp_idle;
    logic [3:0] exp_push;
    if (reset) begin
      g = -100; m_starve = 0; m_pdata = '0;
    end else if (cyc >= g + 4) begin
      el0 = init && q0.size() != 0 && !dest_almost_full[q0[0][DW-1 -: 2]];
      el1 = init && q1.size() != 0 && !dest_almost_full[q1[0][DW-1 -: 2]];
      g0  = el0 && !(el1 && starve_limit != 0 && m_starve >= int'(starve_limit));
      g1  = el1 && !g0;
      if (g0 || g1) begin
        g = cyc; m_src = g1;
        m_word = g1 ? q1[0] : q0[0];
        glog.push_back(g1 ? 1 : 0);
        gcyc.push_back(cyc);
        if (g1) m_starve = 0;
        else if (q1.size() != 0) m_starve = (m_starve < 15) ? m_starve + 1 : 15;
        else m_starve = 0;
      end
    end
    if (!reset && cyc == g + 2) m_pdata = m_word;
    exp_push = (!reset && cyc == g + 2) ? (4'b0001 << m_word[DW-1 -: 2]) : 4'b0000;
    exp_idle = !(cyc >= g && cyc <= g + 2);
    chk("rd_vc0", {31'd0, rd_vc0}, {31'd0, (cyc == g) && !m_src});
    chk("rd_vc1", {31'd0, rd_vc1}, {31'd0, (cyc == g) && m_src});
    chk("push", {28'd0, push}, {28'd0, exp_push});
    chk("push_data", {26'd0, push_data}, {26'd0, m_pdata});
    chk("idle", {31'd0, idle}, {31'd0, exp_idle});
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    model_step();
    if (rd_vc0 === 1'b1 && q0.size() != 0) data_vc0 = q0.pop_front();
    if (rd_vc1 === 1'b1 && q1.size() != 0) data_vc1 = q1.pop_front();
    update_view();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  initial begin
    int exp2[6];
    int n;
    reset = 1'b1; init = 1'b0; dest_almost_full = 4'b0000; starve_limit = 4'd0;
    data_vc0 = '0; data_vc1 = '0;
    update_view();

    // 1: single word on VC0 routed to D1
    q0.push_back(6'b010011); init = 1'b1; update_view();
    do_reset();
    chk("reset_idle", {31'd0, idle}, 32'd1);
    chk("reset_push", {28'd0, push}, 32'd0);
    tick(); chk("t1_rd0", {31'd0, rd_vc0}, 32'd1);
    tick(); tick();
    chk("t1_push", {28'd0, push}, 32'h2);
    chk("t1_data", {26'd0, push_data}, 32'h13);
    tick(); chk("t1_push_off", {28'd0, push}, 32'd0);

    // 2: starvation limit 2 with both VCs loaded
    do_reset();
    starve_limit = 4'd2; glog.delete(); gcyc.delete();
    for (int i = 0; i < 5; i++) begin
      q0.push_back(DW'($urandom)); q1.push_back(DW'($urandom));
    end
    update_view();
    repeat (40) tick();
    exp2 = '{0, 0, 1, 0, 0, 1};
    chk("t2_count", {31'd0, glog.size() >= 6}, 32'd1);
    for (int i = 0; i < 6 && i < glog.size(); i++) chk("t2_order", glog[i], exp2[i]);
    for (int i = 1; i < 6 && i < gcyc.size(); i++) chk("t2_spacing", gcyc[i] - gcyc[i-1], 32'd4);

    // 3: VC0 blocked by almost-full on D3
    do_reset();
    starve_limit = 4'd0; q0.delete(); q1.delete(); glog.delete();
    q0.push_back(6'b110001); q1.push_back(6'b000101);
    dest_almost_full = 4'b1000; update_view();
    tick(); chk("t3_rd1", {31'd0, rd_vc1}, 32'd1);
    repeat (8) tick();
    chk("t3_held", glog.size(), 32'd1);
    dest_almost_full = 4'b0000;
    repeat (6) tick();
    chk("t3_count", glog.size(), 32'd2);
    if (glog.size() >= 2) chk("t3_vc0", glog[1], 32'd0);

    // 4: init dropped during POP
    do_reset();
    q0.delete(); q1.delete(); glog.delete();
    q0.push_back(6'b100111); q0.push_back(6'b011010); update_view();
    tick(); chk("t4_rd0", {31'd0, rd_vc0}, 32'd1);
    init = 1'b0;
    tick(); tick();
    chk("t4_push", {28'd0, push}, 32'h4);
    chk("t4_data", {26'd0, push_data}, 32'h27);
    tick(); chk("t4_idle", {31'd0, idle}, 32'd1);
    repeat (6) tick();
    chk("t4_no_grant", glog.size(), 32'd1);

    // 5: reset during CAP drops the word
    init = 1'b1;
    tick(); chk("t5_rd0", {31'd0, rd_vc0}, 32'd1);
    tick();
    reset = 1'b1;
    tick();
    chk("t5_push", {28'd0, push}, 32'd0);
    chk("t5_data", {26'd0, push_data}, 32'd0);
    chk("t5_rd", {30'd0, rd_vc1, rd_vc0}, 32'd0);
    chk("t5_idle", {31'd0, idle}, 32'd1);
    reset = 1'b0;

    // 6: strict priority
    do_reset();
    q0.delete(); q1.delete(); glog.delete(); starve_limit = 4'd0;
    for (int i = 0; i < 6; i++) begin
      q0.push_back(DW'($urandom)); q1.push_back(DW'($urandom));
    end
    update_view();
    repeat (30) tick();
    chk("t6_count", {31'd0, glog.size() >= 7}, 32'd1);
    for (int i = 0; i < 6 && i < glog.size(); i++) chk("t6_vc0", glog[i], 32'd0);
    if (glog.size() >= 7) chk("t6_vc1", glog[6], 32'd1);

    // Grant decision table, each entry from a fresh reset
    vecs[0] = '{1'b1, 1'b1, 2'd0, 2'd0, 4'b0000, 1'b1, 2'b01};
    vecs[1] = '{1'b0, 1'b1, 2'd0, 2'd2, 4'b0000, 1'b1, 2'b10};
    vecs[2] = '{1'b1, 1'b1, 2'd3, 2'd0, 4'b1000, 1'b1, 2'b10};
    vecs[3] = '{1'b1, 1'b1, 2'd2, 2'd2, 4'b0100, 1'b1, 2'b00};
    vecs[4] = '{1'b1, 1'b1, 2'd0, 2'd1, 4'b0000, 1'b0, 2'b00};
    vecs[5] = '{1'b1, 1'b1, 2'd1, 2'd3, 4'b1000, 1'b1, 2'b01};
    vecs[6] = '{1'b0, 1'b0, 2'd0, 2'd0, 4'b0000, 1'b1, 2'b00};
    vecs[7] = '{1'b1, 1'b0, 2'd1, 2'd0, 4'b0010, 1'b1, 2'b00};
    vecs[8] = '{1'b1, 1'b1, 2'd1, 2'd1, 4'b0001, 1'b1, 2'b01};
    for (int v = 0; v < 9; v++) begin
      reset = 1'b1;
      tick();
      q0.delete(); q1.delete();
      if (vecs[v].has0) q0.push_back({vecs[v].d0, 4'($urandom)});
      if (vecs[v].has1) q1.push_back({vecs[v].d1, 4'($urandom)});
      dest_almost_full = vecs[v].daf; init = vecs[v].en; starve_limit = 4'd0;
      update_view();
      tick();
      reset = 1'b0;
      tick();
      chk($sformatf("vec%0d", v), {30'd0, rd_vc1, rd_vc0}, {30'd0, vecs[v].exp_rd});
      repeat (4) tick();
    end

    // Randomized traffic against the reference model
    q0.delete(); q1.delete();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 2) == 0 && q0.size() < 6) q0.push_back(DW'($urandom));
      if ($urandom_range(0, 2) == 0 && q1.size() < 6) q1.push_back(DW'($urandom));
      init = ($urandom_range(0, 15) != 0);
      dest_almost_full = 4'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 49) == 0) starve_limit = 4'($urandom_range(0, 3));
      reset = ($urandom_range(0, 199) == 0);
      update_view();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
